// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing control for the 5-stage RV32I pipeline:
// forwarding, load-use stalls, branch flushes, dmem freeze, init drain, timeout.
module pipeline_hazard_ctrl #(
    parameter int INIT_CYCLES = 4,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic [4:0]       rs1_e,
    input  logic [4:0]       rs2_e,
    input  logic [4:0]       rd_e,
    input  logic [4:0]       rd_m,
    input  logic [4:0]       rd_w,
    input  logic             reg_write_m,
    input  logic             reg_write_w,
    input  logic [2:0]       result_src_e,
    input  logic             pc_src_e,
    input  logic             dmem_req_m,
    input  logic             dmem_ready,
    output logic [1:0]       forward_a_e,
    output logic [1:0]       forward_b_e,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             stall_m,
    output logic             flush_d,
    output logic             flush_e,
    output logic             flush_w,
    output logic             bus_error,
    output logic [CNT_W-1:0] stall_count
);

    localparam int WW_RAW = $clog2(MEM_TIMEOUT + 1);
    localparam int WW     = (WW_RAW > 8) ? WW_RAW : 8;
    localparam int IW_RAW = $clog2(INIT_CYCLES + 1);
    localparam int IW     = (IW_RAW > 1) ? IW_RAW : 1;

    localparam logic [IW-1:0] ICNT_LAST = IW'(INIT_CYCLES - 1);
    localparam logic [WW-1:0] WCNT_LAST = WW'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_RUN   = 2'd1,
        S_ERROR = 2'd2
    } state_t;

    state_t          state;
    logic [IW-1:0]   icnt;
    logic [WW-1:0]   wcnt;

    logic mem_wait;
    logic lw_stall;
    logic in_init;
    logic in_err;

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic       wr_m,
        input logic [4:0] dst_m,
        input logic       wr_w,
        input logic [4:0] dst_w
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (wr_m && dst_m != 5'd0 && dst_m == rs)
            sel = 2'b10;
        else if (wr_w && dst_w != 5'd0 && dst_w == rs)
            sel = 2'b01;
        return sel;
    endfunction

    assign mem_wait = dmem_req_m && !dmem_ready;
    assign lw_stall = (result_src_e == 3'b001) && (rd_e != 5'd0) &&
                      ((rd_e == rs1_d) || (rd_e == rs2_d));

    // Held in reset, the pipeline sees the same drain pattern as INIT.
    assign in_init = !rst_n || (state == S_INIT);
    assign in_err  = rst_n && (state == S_ERROR);

    always_comb begin
        forward_a_e = 2'b00;
        forward_b_e = 2'b00;
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        stall_e     = 1'b0;
        stall_m     = 1'b0;
        flush_d     = 1'b0;
        flush_e     = 1'b0;
        flush_w     = 1'b0;
        unique case (1'b1)
            in_init: begin
                stall_f = 1'b1;
                flush_d = 1'b1;
                flush_e = 1'b1;
                flush_w = 1'b1;
            end
            in_err: begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                stall_m = 1'b1;
                flush_d = 1'b1;
                flush_e = 1'b1;
                flush_w = 1'b1;
            end
            default: begin
                forward_a_e = fwd_sel(rs1_e, reg_write_m, rd_m,
                                      reg_write_w, rd_w);
                forward_b_e = fwd_sel(rs2_e, reg_write_m, rd_m,
                                      reg_write_w, rd_w);
                if (mem_wait) begin
                    // E is frozen, so branch/load-use resolve after release.
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    stall_e = 1'b1;
                    stall_m = 1'b1;
                    flush_w = 1'b1;
                end else begin
                    stall_f = lw_stall;
                    stall_d = lw_stall;
                    flush_e = lw_stall || pc_src_e;
                    flush_d = pc_src_e;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_INIT;
            icnt        <= '0;
            wcnt        <= '0;
            bus_error   <= 1'b0;
            stall_count <= '0;
        end else begin
            if (stall_f && stall_count != '1)
                stall_count <= stall_count + 1'b1;
            case (state)
                S_INIT: begin
                    icnt <= icnt + 1'b1;
                    if (icnt == ICNT_LAST)
                        state <= S_RUN;
                end
                S_RUN: begin
                    if (mem_wait) begin
                        wcnt <= wcnt + 1'b1;
                        if (wcnt == WCNT_LAST) begin
                            state     <= S_ERROR;
                            bus_error <= 1'b1;
                        end
                    end else begin
                        wcnt <= '0;
                    end
                end
                S_ERROR: begin
                    bus_error <= 1'b1;
                end
                default: begin
                    state     <= S_ERROR;
                    bus_error <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus
// randomized traffic against a cycle-count based reference model.
module tb_pipeline_hazard_ctrl;

    localparam int     INIT    = 4;
    localparam int     TO      = 8;
    localparam int     CW      = 32;
    localparam longint CNT_MAX = 64'hFFFF_FFFF;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4:0]    rs1_d, rs2_d, rs1_e, rs2_e;
    logic [4:0]    rd_e, rd_m, rd_w;
    logic          reg_write_m, reg_write_w;
    logic [2:0]    result_src_e;
    logic          pc_src_e, dmem_req_m, dmem_ready;
    logic [1:0]    forward_a_e, forward_b_e;
    logic          stall_f, stall_d, stall_e, stall_m;
    logic          flush_d, flush_e, flush_w, bus_error;
    logic [CW-1:0] stall_count;

    pipeline_hazard_ctrl #(
        .INIT_CYCLES(INIT),
        .MEM_TIMEOUT(TO),
        .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_d(rs1_d), .rs2_d(rs2_d),
        .rs1_e(rs1_e), .rs2_e(rs2_e),
        .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
        .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
        .result_src_e(result_src_e), .pc_src_e(pc_src_e),
        .dmem_req_m(dmem_req_m), .dmem_ready(dmem_ready),
        .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
        .stall_f(stall_f), .stall_d(stall_d),
        .stall_e(stall_e), .stall_m(stall_m),
        .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
        .bus_error(bus_error), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Bit order: fa[11:10] fb[9:8] sf sd se sm fd fe fw be
    logic [11:0] obs;
    assign obs = {forward_a_e, forward_b_e, stall_f, stall_d, stall_e,
                  stall_m, flush_d, flush_e, flush_w, bus_error};

    // Reference model: cycles since reset release, consecutive waits,
    // sticky error and stall tally.
    int     m_since;
    int     m_consec;
    bit     m_err;
    longint m_cnt;

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (reg_write_m && rd_m != 0 && rd_m == rs) return 2'b10;
        if (reg_write_w && rd_w != 0 && rd_w == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [11:0] ref_out();
        logic [1:0] fa, fb;
        logic sf, sd, se, sm, fd, fe, fw;
        bit wt, lu;
        fa = 0; fb = 0;
        sf = 0; sd = 0; se = 0; sm = 0;
        fd = 0; fe = 0; fw = 0;
        wt = dmem_req_m && !dmem_ready;
        lu = result_src_e == 3'b001 && rd_e != 0 &&
             (rd_e == rs1_d || rd_e == rs2_d);
        if (!rst_n || (!m_err && m_since < INIT)) begin
            sf = 1; fd = 1; fe = 1; fw = 1;
        end else if (m_err) begin
            sf = 1; sd = 1; se = 1; sm = 1;
            fd = 1; fe = 1; fw = 1;
        end else begin
            fa = ref_fwd(rs1_e);
            fb = ref_fwd(rs2_e);
            if (wt) begin
                sf = 1; sd = 1; se = 1; sm = 1; fw = 1;
            end else begin
                sf = lu; sd = lu;
                fe = lu || pc_src_e;
                fd = pc_src_e;
            end
        end
        return {fa, fb, sf, sd, se, sm, fd, fe, fw, m_err};
    endfunction

    function automatic bit ref_stall_f();
        logic [11:0] v;
        v = ref_out();
        return v[7];
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_since  <= 0;
            m_consec <= 0;
            m_err    <= 0;
            m_cnt    <= 0;
        end else begin
            if (ref_stall_f() && m_cnt < CNT_MAX)
                m_cnt <= m_cnt + 1;
            if (m_since < INIT) begin
                m_since <= m_since + 1;
            end else if (!m_err) begin
                if (dmem_req_m && !dmem_ready) begin
                    m_consec <= m_consec + 1;
                    if (m_consec + 1 == TO) m_err <= 1;
                end else begin
                    m_consec <= 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0;
        rd_e = 0; rd_m = 0; rd_w = 0;
        reg_write_m = 0; reg_write_w = 0;
        result_src_e = 0; pc_src_e = 0;
        dmem_req_m = 0; dmem_ready = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        clear_inputs();
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (obs !== 12'b0000_1000_1110) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected %b",
                     obs, 12'b0000_1000_1110);
        end
        checks++;
        if (stall_count !== 0) begin
            errors++;
            $display("FAIL reset_count: got %0d expected 0", stall_count);
        end
        tick();
        rst_n = 1;
        for (int i = 0; i < INIT; i++) begin
            @(negedge clk);
            checks++;
            if ({stall_f, flush_d, flush_e, flush_w} !== 4'hF ||
                obs !== ref_out()) begin
                errors++;
                $display("FAIL init_cycle%0d: got %b expected %b",
                         i, obs, ref_out());
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if ({stall_f, flush_d, flush_e, flush_w} !== 4'h0) begin
            errors++;
            $display("FAIL init_release: got %b expected 0000",
                     {stall_f, flush_d, flush_e, flush_w});
        end
        checks++;
        if (stall_count !== 4) begin
            errors++;
            $display("FAIL init_count: got %0d expected 4", stall_count);
        end
    endtask

    task automatic test_forward();
        clear_inputs();
        rd_m = 5; reg_write_m = 1;
        rd_w = 5; reg_write_w = 1;
        rs1_e = 5; rs2_e = 0;
        @(negedge clk);
        checks++;
        if ({forward_a_e, forward_b_e} !== 4'b1000) begin
            errors++;
            $display("FAIL fwd_m_wins: got %b expected 1000",
                     {forward_a_e, forward_b_e});
        end
        tick();
        reg_write_m = 0;
        @(negedge clk);
        checks++;
        if (forward_a_e !== 2'b01) begin
            errors++;
            $display("FAIL fwd_w: got %b expected 01", forward_a_e);
        end
        tick();
        reg_write_m = 1; rd_m = 0; rs1_e = 0;
        rd_w = 0; rs2_e = 0;
        @(negedge clk);
        checks++;
        if ({forward_a_e, forward_b_e} !== 4'b0000) begin
            errors++;
            $display("FAIL fwd_x0: got %b expected 0000",
                     {forward_a_e, forward_b_e});
        end
        tick();
        rd_m = 9; rs2_e = 9; rd_w = 3; rs1_e = 3;
        @(negedge clk);
        checks++;
        if ({forward_a_e, forward_b_e} !== 4'b0110 ||
            obs !== ref_out()) begin
            errors++;
            $display("FAIL fwd_split: got %b expected 0110",
                     {forward_a_e, forward_b_e});
        end
        tick();
    endtask

    task automatic test_load_use();
        clear_inputs();
        result_src_e = 3'b001; rd_e = 7; rs2_d = 7;
        @(negedge clk);
        checks++;
        if (obs[7:1] !== 7'b1100_010) begin
            errors++;
            $display("FAIL lw_stall: got %b expected 1100010", obs[7:1]);
        end
        tick();
        rd_e = 0; rs2_d = 0;
        @(negedge clk);
        checks++;
        if (obs[7:1] !== 7'b0) begin
            errors++;
            $display("FAIL lw_x0: got %b expected 0000000", obs[7:1]);
        end
        tick();
        result_src_e = 3'b011; rd_e = 4; rs1_d = 4;
        @(negedge clk);
        checks++;
        if (obs[7:1] !== 7'b0) begin
            errors++;
            $display("FAIL lw_nonload: got %b expected 0000000", obs[7:1]);
        end
        checks++;
        if (stall_count !== m_cnt[CW-1:0]) begin
            errors++;
            $display("FAIL lw_count: got %0d expected %0d",
                     stall_count, m_cnt);
        end
        tick();
    endtask

    task automatic test_branch_lw();
        clear_inputs();
        result_src_e = 3'b001; rd_e = 12; rs1_d = 12; pc_src_e = 1;
        @(negedge clk);
        checks++;
        if (obs[7:1] !== 7'b1100_110) begin
            errors++;
            $display("FAIL br_lw: got %b expected 1100110", obs[7:1]);
        end
        tick();
        result_src_e = 0;
        @(negedge clk);
        checks++;
        if (obs[7:1] !== 7'b0000_110) begin
            errors++;
            $display("FAIL br_only: got %b expected 0000110", obs[7:1]);
        end
        tick();
    endtask

    task automatic test_mem_wait();
        clear_inputs();
        dmem_req_m = 1; dmem_ready = 0; pc_src_e = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs[7:1] !== 7'b1111_001 || obs !== ref_out()) begin
                errors++;
                $display("FAIL mem_wait%0d: got %b expected 1111001",
                         i, obs[7:1]);
            end
            tick();
        end
        dmem_ready = 1;
        @(negedge clk);
        checks++;
        if (obs[7:1] !== 7'b0000_110) begin
            errors++;
            $display("FAIL mem_release: got %b expected 0000110", obs[7:1]);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rs1_d = 5'($urandom_range(0, 3));
            rs2_d = 5'($urandom_range(0, 3));
            rs1_e = 5'($urandom_range(0, 3));
            rs2_e = 5'($urandom_range(0, 3));
            rd_e  = 5'($urandom_range(0, 3));
            rd_m  = 5'($urandom_range(0, 3));
            rd_w  = 5'($urandom_range(0, 3));
            reg_write_m  = 1'($urandom);
            reg_write_w  = 1'($urandom);
            result_src_e = ($urandom_range(0, 1) == 1) ? 3'b001
                                                       : 3'($urandom);
            pc_src_e     = ($urandom_range(0, 3) == 0);
            dmem_req_m   = 1'($urandom);
            dmem_ready   = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            checks++;
            if (obs !== ref_out()) begin
                errors++;
                $display("FAIL rand_out%0d: got %b expected %b",
                         i, obs, ref_out());
            end
            checks++;
            if (stall_count !== m_cnt[CW-1:0]) begin
                errors++;
                $display("FAIL rand_count%0d: got %0d expected %0d",
                         i, stall_count, m_cnt);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_timeout();
        clear_inputs();
        rst_n = 0;
        tick();
        rst_n = 1;
        for (int i = 0; i < INIT; i++) tick();
        dmem_req_m = 1; dmem_ready = 0;
        for (int i = 0; i < TO + 2; i++) begin
            @(negedge clk);
            checks++;
            if (i < TO) begin
                if (obs[7:0] !== 8'b1111_0010 || obs !== ref_out()) begin
                    errors++;
                    $display("FAIL tmo_wait%0d: got %b expected 11110010",
                             i, obs[7:0]);
                end
            end else begin
                if (obs[7:0] !== 8'hFF || obs !== ref_out()) begin
                    errors++;
                    $display("FAIL tmo_err%0d: got %b expected 11111111",
                             i, obs[7:0]);
                end
            end
            tick();
        end
        dmem_ready = 1; dmem_req_m = 0;
        @(negedge clk);
        checks++;
        if (obs[7:0] !== 8'hFF) begin
            errors++;
            $display("FAIL tmo_sticky: got %b expected 11111111", obs[7:0]);
        end
        tick();
        rst_n = 0;
        @(negedge clk);
        checks++;
        if (obs !== 12'b0000_1000_1111) begin
            errors++;
            $display("FAIL tmo_in_reset: got %b expected %b",
                     obs, 12'b0000_1000_1111);
        end
        tick();
        rst_n = 1;
        @(negedge clk);
        checks++;
        if (obs !== 12'b0000_1000_1110 || stall_count !== 0) begin
            errors++;
            $display("FAIL tmo_reinit: got %b/%0d expected %b/0",
                     obs, stall_count, 12'b0000_1000_1110);
        end
        tick();
    endtask

    initial begin
        rst_n = 0;
        clear_inputs();
        test_reset();
        test_forward();
        test_load_use();
        test_branch_lw();
        test_mem_wait();
        test_random();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
